grid_stimulus_gen: RTL and testbench

Parametrised, frame-synchronous stimulus source for the board renderer. It replaces hard-tied grid/state constants with a sequencer that regenerates an N = GRID_DIM*GRID_DIM cell board every FRAMES_PER_STEP frames. Four modes are supported: static ramp, rotating ramp, LFSR random and state cycling. It sits between the VGA frame timing and the graphics block; the grid is double-buffered so the displayed board changes atomically.

---
 rtl/grid_stim_pkg.sv | 35 +++
 rtl/grid_stimulus_gen_lfsr16.sv | 29 ++
 rtl/grid_stimulus_gen.sv | 197 +++++++++++++++++++
 tb/tb_grid_stimulus_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/grid_stim_pkg.sv
// Shared types and helpers for the grid stimulus generator.
// Contents:
//   mode_t    - stimulus mode selector encoding
//   fsm_t     - sequencer state encoding
//   LFSR_MASK - Galois feedback taps for the 16-bit right-shifting LFSR
//   seed_fix  - maps an all-zero seed to 1 so the LFSR can never lock up
package grid_stim_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC      = 2'd0,
    MODE_ROTATE      = 2'd1,
    MODE_RANDOM      = 2'd2,
    MODE_STATE_CYCLE = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_COMMIT = 2'd2
  } fsm_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // The all-zero state is a fixed point of the LFSR, so never load it.
  function automatic logic [15:0] seed_fix(input logic [15:0] seed);
    logic [15:0] fixed;
    if (seed == 16'h0000) begin
      fixed = 16'h0001;
    end else begin
      fixed = seed;
    end
    return fixed;
  endfunction

endpackage

// File: rtl/grid_stimulus_gen_lfsr16.sv
// 16-bit Galois LFSR, right shift, taps LFSR_MASK.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset, reloads the (fixed-up) seed
//   seed    - reset value; zero is replaced by 1
//   advance - step the LFSR once on this edge
//   value   - current LFSR state
module lfsr16
  import grid_stim_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] value
);

  // LFSR state register: reload on reset, shift only when asked.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= seed_fix(seed);
    end else if (advance) begin
      value <= (value >> 1) ^ (value[0] ? LFSR_MASK : 16'h0000);
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/grid_stimulus_gen.sv
// Frame-synchronous board stimulus source. Every FRAMES_PER_STEP frame ticks
// it regenerates an N = GRID_DIM*GRID_DIM cell board into a back buffer
// (one cell per cycle) and then copies it to the displayed front buffer in a
// single cycle, so the renderer never sees a half-built board.
// Ports:
//   clk         - system clock
//   rst         - synchronous active-high reset, overrides everything
//   frame_tick  - one-cycle pulse per video frame
//   mode        - 0 static ramp, 1 rotating ramp, 2 LFSR random, 3 state cycle
//   hold        - freeze the frame counter (no new steps start)
//   grid_flat   - front buffer, cell i at [i*CELL_W +: CELL_W]
//   state       - game-state code for the renderer
//   step_strobe - pulses on the first cycle a new grid_flat is visible
//   busy        - high while filling or committing
//   overrun     - sticky, a step became due while the sequencer was busy
module grid_stimulus_gen
  import grid_stim_pkg::*;
#(
  parameter int          GRID_DIM        = 4,
  parameter int          CELL_W          = 4,
  parameter int          FRAMES_PER_STEP = 60,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                frame_tick,
  input  logic [1:0]                          mode,
  input  logic                                hold,
  output logic [GRID_DIM*GRID_DIM*CELL_W-1:0] grid_flat,
  output logic [1:0]                          state,
  output logic                                step_strobe,
  output logic                                busy,
  output logic                                overrun
);

  localparam int N     = GRID_DIM * GRID_DIM;
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  fsm_t              fsm;
  fsm_t              fsm_next;
  logic [CNT_W-1:0]  frame_cnt;
  logic              step_due;
  logic              step_req;
  logic [7:0]        step_idx;
  mode_t             cur_mode;
  mode_t             last_mode;
  mode_t             mode_in;
  logic [IDX_W-1:0]  fill_idx;
  logic              fill_last;
  logic [N*CELL_W-1:0] back_buf;
  logic [N*CELL_W-1:0] ramp_flat;
  logic [15:0]       lfsr_value;
  logic              lfsr_adv;
  logic [7:0]        k_ext;
  logic [7:0]        rot_sum;
  logic [CELL_W-1:0] cell_val;

  // Reset image of both buffers: cell i holds i truncated to CELL_W bits.
  for (genvar g = 0; g < N; g++) begin : g_ramp
    localparam logic [7:0] RAMP_V = 8'(g);
    assign ramp_flat[g*CELL_W +: CELL_W] = RAMP_V[CELL_W-1:0];
  end

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .seed    (LFSR_SEED),
    .advance (lfsr_adv),
    .value   (lfsr_value)
  );

  // Step-due decode, fill progress and per-cell value for the current mode.
  always_comb begin
    step_due  = 1'b0;
    mode_in   = mode_t'(mode);
    fill_last = (fill_idx == IDX_LAST);
    lfsr_adv  = (fsm == S_FILL) && (cur_mode == MODE_RANDOM);
    k_ext     = 8'(fill_idx);
    rot_sum   = k_ext + step_idx;
    cell_val  = k_ext[CELL_W-1:0];
    if (frame_tick && !hold && (frame_cnt == CNT_MAX)) begin
      step_due = 1'b1;
    end else begin
      step_due = 1'b0;
    end
    case (cur_mode)
      MODE_STATIC:      cell_val = k_ext[CELL_W-1:0];
      MODE_ROTATE:      cell_val = rot_sum[CELL_W-1:0];
      MODE_RANDOM:      cell_val = lfsr_value[CELL_W-1:0];
      MODE_STATE_CYCLE: cell_val = k_ext[CELL_W-1:0];
      default:          cell_val = k_ext[CELL_W-1:0];
    endcase
  end

  // Sequencer next-state logic.
  always_comb begin
    fsm_next = fsm;
    case (fsm)
      S_IDLE: begin
        if (step_req) begin
          fsm_next = S_FILL;
        end else begin
          fsm_next = S_IDLE;
        end
      end
      S_FILL: begin
        if (fill_last) begin
          fsm_next = S_COMMIT;
        end else begin
          fsm_next = S_FILL;
        end
      end
      S_COMMIT: fsm_next = S_IDLE;
      default:  fsm_next = S_IDLE;
    endcase
  end

  // Sequencer state register and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm  <= S_IDLE;
      busy <= 1'b0;
    end else begin
      fsm  <= fsm_next;
      busy <= (fsm_next != S_IDLE);
    end
  end

  // Frame counter; keeps counting (and wrapping) even while a step runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (step_due) begin
      frame_cnt <= '0;
    end else if (frame_tick && !hold) begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end else begin
      frame_cnt <= frame_cnt;
    end
  end

  // A due step becomes a one-cycle request that launches FILL on the next
  // edge. A step due while a request is pending or the FSM is active is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_req <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      step_req <= step_due && (fsm == S_IDLE) && !step_req;
      overrun  <= overrun | (step_due && ((fsm != S_IDLE) || step_req));
    end
  end

  // Mode latch, back-buffer fill and atomic commit to the front buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_mode    <= MODE_STATIC;
      last_mode   <= MODE_STATIC;
      step_idx    <= 8'd0;
      fill_idx    <= '0;
      back_buf    <= ramp_flat;
      grid_flat   <= ramp_flat;
      state       <= 2'd0;
      step_strobe <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (step_req) begin
            cur_mode  <= mode_in;
            last_mode <= mode_in;
            step_idx  <= (mode_in != last_mode) ? 8'd0 : step_idx + 8'd1;
            fill_idx  <= '0;
          end else begin
            fill_idx  <= fill_idx;
          end
        end
        S_FILL: begin
          back_buf[int'(fill_idx)*CELL_W +: CELL_W] <= cell_val;
          fill_idx <= fill_idx + IDX_W'(1);
        end
        S_COMMIT: begin
          grid_flat   <= back_buf;
          state       <= (cur_mode == MODE_STATE_CYCLE) ? step_idx[1:0] : 2'd0;
          step_strobe <= 1'b1;
        end
        default: begin
          step_strobe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_stimulus_gen.sv
module tb_grid_stimulus_gen;

  localparam int N = 16;
  localparam logic [63:0] RAMP = 64'hFEDC_BA98_7654_3210;

  logic        clk = 1'b0;
  logic        rst, frame_tick, hold;
  logic [1:0]  mode;
  logic [63:0] grid_flat;
  logic [1:0]  state;
  logic        step_strobe, busy, overrun;

  logic        rst1, frame_tick1, hold1;
  logic [1:0]  mode1;
  logic [63:0] grid_flat1;
  logic [1:0]  state1;
  logic        step_strobe1, busy1, overrun1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  grid_stimulus_gen #(.GRID_DIM(4), .CELL_W(4), .FRAMES_PER_STEP(2), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .mode(mode), .hold(hold),
    .grid_flat(grid_flat), .state(state), .step_strobe(step_strobe),
    .busy(busy), .overrun(overrun)
  );

  grid_stimulus_gen #(.GRID_DIM(4), .CELL_W(4), .FRAMES_PER_STEP(1), .LFSR_SEED(16'hACE1)) dut1 (
    .clk(clk), .rst(rst1), .frame_tick(frame_tick1), .mode(mode1), .hold(hold1),
    .grid_flat(grid_flat1), .state(state1), .step_strobe(step_strobe1),
    .busy(busy1), .overrun(overrun1)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
    end
  endtask

  // Edges from the step-due edge until step_strobe is seen; -1 on timeout.
  task automatic wait_strobe(output int lat, output logic busy_early);
    lat = -1;
    busy_early = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 2) busy_early = busy;
      if (step_strobe) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic count_strobes(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (step_strobe) c++;
    end
  endtask

  initial begin
    int          lat;
    int          cnt;
    logic        b_early;
    logic [63:0] exp;
    logic [63:0] prev;
    logic [15:0] v;
    logic [1:0]  st_exp [5];

    rst = 1'b0; frame_tick = 1'b0; hold = 1'b0; mode = 2'd0;
    rst1 = 1'b0; frame_tick1 = 1'b0; hold1 = 1'b0; mode1 = 2'd0;
    @(posedge clk); #1;

    // 1: reset state and a static step
    do_reset();
    chk("rst_grid", grid_flat, RAMP);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_strobe", 64'(step_strobe), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    do_ticks(1);
    chk("one_tick_idle", 64'(busy), 64'd0);
    do_ticks(1);
    wait_strobe(lat, b_early);
    chk("static_latency", 64'(lat), 64'(N + 2));
    chk("static_busy_fill", 64'(b_early), 64'd1);
    chk("static_grid", grid_flat, RAMP);
    chk("static_state", 64'(state), 64'd0);
    chk("static_overrun", 64'(overrun), 64'd0);
    chk("static_busy_done", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("strobe_one_cycle", 64'(step_strobe), 64'd0);

    // 2: rotating ramp, step_idx 0..3
    do_reset();
    mode = 2'd1;
    for (int j = 0; j < 4; j++) begin
      do_ticks(2);
      wait_strobe(lat, b_early);
      chk("rot_latency", 64'(lat), 64'(N + 2));
      for (int k = 0; k < N; k++) exp[k*4 +: 4] = 4'(k + j);
      chk("rot_grid", grid_flat, exp);
    end
    chk("rot_cell0", 64'(grid_flat[3:0]), 64'd3);
    chk("rot_cell15", 64'(grid_flat[63:60]), 64'd2);
    chk("rot_cell12", 64'(grid_flat[51:48]), 64'd15);

    // 3: random cells from the LFSR
    do_reset();
    mode = 2'd2;
    do_ticks(2);
    wait_strobe(lat, b_early);
    chk("rnd_latency", 64'(lat), 64'(N + 2));
    chk("rnd_cell0", 64'(grid_flat[3:0]), 64'h1);
    chk("rnd_cell1", 64'(grid_flat[7:4]), 64'h0);
    v = 16'hACE1;
    for (int k = 0; k < N; k++) begin
      exp[k*4 +: 4] = v[3:0];
      v = lfsr_next(v);
    end
    chk("rnd_grid", grid_flat, exp);

    // 4: state cycling
    do_reset();
    mode = 2'd3;
    st_exp[0] = 2'd0; st_exp[1] = 2'd1; st_exp[2] = 2'd2; st_exp[3] = 2'd3; st_exp[4] = 2'd0;
    for (int j = 0; j < 5; j++) begin
      do_ticks(2);
      wait_strobe(lat, b_early);
      chk("cyc_latency", 64'(lat), 64'(N + 2));
      chk("cyc_state", 64'(state), 64'(st_exp[j]));
    end
    chk("cyc_grid", grid_flat, RAMP);

    // 5: FRAMES_PER_STEP=1 with a tick every cycle
    mode1 = 2'd1;
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    frame_tick1 = 1'b1;
    prev = grid_flat1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      chk("ovr_commit_only", 64'((grid_flat1 !== prev) && !step_strobe1), 64'd0);
      if (step_strobe1) cnt++;
      prev = grid_flat1;
    end
    chk("ovr_strobes", 64'(cnt), 64'd3);
    chk("ovr_cell0", 64'(grid_flat1[3:0]), 64'd2);
    chk("ovr_set", 64'(overrun1), 64'd1);
    frame_tick1 = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("ovr_sticky", 64'(overrun1), 64'd1);
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    chk("ovr_cleared", 64'(overrun1), 64'd0);

    // 6: reset mid-FILL, then hold
    do_reset();
    mode = 2'd1;
    do_ticks(2);
    do_ticks(2);
    repeat (6) @(posedge clk);
    #1;
    chk("midfill_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midfill_grid", grid_flat, RAMP);
    chk("midfill_busy_clr", 64'(busy), 64'd0);
    chk("midfill_strobe", 64'(step_strobe), 64'd0);
    count_strobes(30, cnt);
    chk("midfill_no_commit", 64'(cnt), 64'd0);
    chk("midfill_grid_after", grid_flat, RAMP);
    hold = 1'b1;
    do_ticks(10);
    count_strobes(30, cnt);
    chk("hold_no_step", 64'(cnt), 64'd0);
    chk("hold_busy", 64'(busy), 64'd0);
    hold = 1'b0;
    do_ticks(1);
    count_strobes(30, cnt);
    chk("hold_cnt_frozen", 64'(cnt), 64'd0);
    do_ticks(1);
    wait_strobe(lat, b_early);
    chk("hold_release_step", 64'(lat), 64'(N + 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
